// File: rtl/unidad_fetch_pkg.sv
// -----------------------------------------------------------------------------
// unidad_fetch_pkg
// Shared constants and types for the instruction-fetch stage and the
// instruction memory it drives. The default memory size lives here so the
// fetch range check and the memory itself agree on the legal address window.
// -----------------------------------------------------------------------------
package unidad_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int                DEFAULT_MEM_BYTES = 1024;

    // One buffered fetch: the instruction word and the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // A fetch address is usable when it is word aligned and the whole word
    // fits inside memory (pc_max is the last legal word address).
    function automatic logic pc_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] pc_max);
        return (addr[1:0] == 2'b00) && (addr <= pc_max);
    endfunction

endpackage

// File: rtl/fifo_fetch.sv
// -----------------------------------------------------------------------------
// fifo_fetch
// Synchronous DEPTH-entry FIFO of fetch entries with flush.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write data_i at the tail
//   pop_i    consume the head
//   flush_i  discard every entry (takes priority over push/pop)
//   data_i   entry to write
//   count_o  number of valid entries (0..DEPTH)
//   head_o   oldest entry, all zeros when empty
// -----------------------------------------------------------------------------
module fifo_fetch
    import unidad_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     data_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok, push_ok;

    // Guard against misuse so the pointers can never drift from count.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q < DEPTH_C) || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + PTR_W'(1);
            if (pop_ok)  head_q <= head_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_ok) begin
            mem_q[tail_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[head_q] : '0;

endmodule

// File: rtl/unidad_fetch.sv
// -----------------------------------------------------------------------------
// unidad_fetch
// Instruction-fetch stage: owns the PC, addresses a combinational instruction
// memory, buffers {instr, pc} and hands it to decode over valid/ready.
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   imem_addr        byte address to instruction memory (the PC register)
//   imem_instr       instruction word for imem_addr, same cycle
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC when redirect_valid=1
//   out_valid        buffer head valid
//   out_ready        decode accepts the head
//   out_instr        head instruction (0 when empty)
//   out_pc           head instruction address (0 when empty)
//   fault            sticky fetch fault (misaligned or out-of-range PC)
// -----------------------------------------------------------------------------
module unidad_fetch
    import unidad_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int                DEPTH     = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);

    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_MAX  = ADDR_W'(MEM_BYTES - PC_STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;

    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      wr_entry;
    logic              pop, push, space, pc_ok;

    fifo_fetch #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (wr_entry),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        pop            = (count != '0) && out_ready;
        // A full buffer still accepts a fetch when decode drains the head
        // in the same cycle, which keeps throughput at one per cycle.
        space          = (count < DEPTH_C) || pop;
        pc_ok          = pc_legal(pc_q, PC_MAX);
        push           = !fault_q && !redirect_valid && space && pc_ok;
        wr_entry.instr = imem_instr;
        wr_entry.pc    = pc_q;

        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            // An illegal target is still loaded so it can be inspected.
            pc_d    = redirect_target;
            fault_d = !pc_legal(redirect_target, PC_MAX);
        end else if (!fault_q && !pc_ok) begin
            fault_d = 1'b1;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr = pc_q;
    assign fault     = fault_q;
    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule
